// File: rtl/patgen_dp_if.sv
// Pixel-bus bundle for the test-pattern source: run/pattern controls in,
// DisplayPort live-video signals out. master = pattern source, slave = sink/controller.
interface patgen_dp_if #(
  parameter int CDEPTH = 8
);
  logic                  EN;
  logic [1:0]            PAT;
  logic [3*CDEPTH-1:0]   SOLID;
  logic                  DP_HSYNC;
  logic                  DP_VSYNC;
  logic                  DP_DE;
  logic [35:0]           DP_DAT;
  logic                  FRAME_START;

  modport master (
    input  EN, PAT, SOLID,
    output DP_HSYNC, DP_VSYNC, DP_DE, DP_DAT, FRAME_START
  );

  modport slave (
    output EN, PAT, SOLID,
    input  DP_HSYNC, DP_VSYNC, DP_DE, DP_DAT, FRAME_START
  );
endinterface

// File: rtl/patgen_dp.sv
// Video test-pattern source with built-in raster timing for the DisplayPort
// live-video bus. Three register stages: counters, pattern/sync, outputs.
module patgen_dp #(
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CDEPTH   = 8,
  parameter int CHK_LOG2 = 4
) (
  input  logic           DCLK,
  input  logic           RST,
  patgen_dp_if.master    vid
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int BW    = H_ACT / 8;
  localparam int BPW   = $clog2(BW + 1);

  localparam logic [HW-1:0]  H_LAST  = HW'(H_TOT - 1);
  localparam logic [VW-1:0]  V_LAST  = VW'(V_TOT - 1);
  localparam logic [BPW-1:0] BP_LAST = BPW'(BW - 1);
  localparam logic           HS_ON   = 1'(HS_POL);
  localparam logic           VS_ON   = 1'(VS_POL);

  // Stage 0 state
  logic [HW-1:0]  hcnt_reg;
  logic [VW-1:0]  vcnt_reg;
  logic [BPW-1:0] bar_px_reg;
  logic [2:0]     bar_idx_reg;

  // Frame-stable pattern controls
  logic [1:0]          pat_sh_reg;
  logic [3*CDEPTH-1:0] solid_sh_reg;

  // Stage 1 registers
  logic        de1_reg, hs1_reg, vs1_reg, fs1_reg;
  logic [35:0] dat1_reg;

  // Counter positions widened so window compares are width-safe
  logic [31:0] hpos, vpos;
  logic        unused_bits;
  assign hpos        = 32'(hcnt_reg);
  assign vpos        = 32'(vcnt_reg);
  assign unused_bits = ^{hpos, vpos};

  logic origin, active, h_win, v_win;
  assign origin = (hcnt_reg == '0) && (vcnt_reg == '0);
  assign active = (hpos < H_ACT) && (vpos < V_ACT);
  assign h_win  = (hpos >= H_ACT + H_FP) && (hpos < H_ACT + H_FP + H_SYNC);
  assign v_win  = (vpos >= V_ACT + V_FP) && (vpos < V_ACT + V_FP + V_SYNC);

  // At the frame origin the live inputs are used directly so a change landing
  // exactly on the origin already applies to the frame it starts.
  logic [1:0]          pat_use;
  logic [3*CDEPTH-1:0] solid_use;
  assign pat_use   = origin ? vid.PAT   : pat_sh_reg;
  assign solid_use = origin ? vid.SOLID : solid_sh_reg;

  // Left-justify one component into its 12-bit lane
  function automatic logic [11:0] pack(input logic [CDEPTH-1:0] c);
    logic [11:0] l;
    l = '0;
    l[11 -: CDEPTH] = c;
    return l;
  endfunction

  // Raster and bar counters; EN low parks everything at the origin
  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      hcnt_reg    <= '0;
      vcnt_reg    <= '0;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
    end else if (!vid.EN) begin
      hcnt_reg    <= '0;
      vcnt_reg    <= '0;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
    end else if (hcnt_reg == H_LAST) begin
      hcnt_reg    <= '0;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
      vcnt_reg    <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
    end else begin
      hcnt_reg <= hcnt_reg + 1'b1;
      if (bar_px_reg == BP_LAST) begin
        bar_px_reg <= '0;
        if (bar_idx_reg != 3'd7) bar_idx_reg <= bar_idx_reg + 3'd1;
      end else begin
        bar_px_reg <= bar_px_reg + 1'b1;
      end
    end
  end

  // Capture pattern controls once per frame so no frame is ever mixed
  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      pat_sh_reg   <= '0;
      solid_sh_reg <= '0;
    end else if (origin) begin
      pat_sh_reg   <= vid.PAT;
      solid_sh_reg <= vid.SOLID;
    end
  end

  // Pattern colour for the current counter position
  logic [CDEPTH-1:0] r_c, g_c, b_c;
  logic [35:0]       dat_c;
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    unique case (pat_use)
      2'd0: begin
        r_c = {CDEPTH{~bar_idx_reg[1]}};
        g_c = {CDEPTH{~bar_idx_reg[2]}};
        b_c = {CDEPTH{~bar_idx_reg[0]}};
      end
      2'd1: begin
        r_c = hpos[CDEPTH-1:0];
        g_c = hpos[CDEPTH-1:0];
        b_c = hpos[CDEPTH-1:0];
      end
      2'd2: begin
        r_c = {CDEPTH{hpos[CHK_LOG2] ^ vpos[CHK_LOG2]}};
        g_c = r_c;
        b_c = r_c;
      end
      default: begin
        r_c = solid_use[3*CDEPTH-1:2*CDEPTH];
        g_c = solid_use[2*CDEPTH-1:CDEPTH];
        b_c = solid_use[CDEPTH-1:0];
      end
    endcase
    dat_c = active ? {pack(b_c), pack(r_c), pack(g_c)} : 36'd0;
  end

  // Stage 1: sync windows, DE, frame marker and colour, all gated by EN
  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      de1_reg  <= 1'b0;
      hs1_reg  <= 1'b0;
      vs1_reg  <= 1'b0;
      fs1_reg  <= 1'b0;
      dat1_reg <= '0;
    end else begin
      de1_reg  <= vid.EN && active;
      hs1_reg  <= vid.EN && h_win;
      vs1_reg  <= vid.EN && v_win;
      fs1_reg  <= vid.EN && origin;
      dat1_reg <= vid.EN ? dat_c : 36'd0;
    end
  end

  // Stage 2: output registers with sync polarity applied
  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      vid.DP_HSYNC    <= ~HS_ON;
      vid.DP_VSYNC    <= ~VS_ON;
      vid.DP_DE       <= 1'b0;
      vid.DP_DAT      <= '0;
      vid.FRAME_START <= 1'b0;
    end else begin
      vid.DP_HSYNC    <= hs1_reg ? HS_ON : ~HS_ON;
      vid.DP_VSYNC    <= vs1_reg ? VS_ON : ~VS_ON;
      vid.DP_DE       <= de1_reg;
      vid.DP_DAT      <= dat1_reg;
      vid.FRAME_START <= fs1_reg;
    end
  end

endmodule
